// File: rtl/vexec_ctrl_pkg.sv
// vexec_pkg: shared opcodes, operand forms, FSM states and latched-instruction layout for vexec_ctrl
package vexec_pkg;

    localparam int PKG_VREG_AW   = 5;
    localparam int PKG_ELEM_SIZE = 32;

    localparam logic [6:0] VOP_ADD = 7'b0000000;
    localparam logic [6:0] VOP_SUB = 7'b0000100;
    localparam logic [6:0] VOP_MUL = 7'b1001011;
    localparam logic [6:0] VOP_DIV = 7'b1001100;

    localparam logic [2:0] VFMT_VV = 3'b000;
    localparam logic [2:0] VFMT_VX = 3'b100;
    localparam logic [2:0] VFMT_VI = 3'b011;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_EX, S_WB, S_ERR} vexec_state_t;

    typedef struct packed {
        logic [6:0]               funct7;
        logic [2:0]               funct3;
        logic [PKG_VREG_AW-1:0]   vd;
        logic [PKG_VREG_AW-1:0]   vs1;
        logic [PKG_VREG_AW-1:0]   vs2;
        logic [PKG_ELEM_SIZE-1:0] scalar;
        logic [4:0]               imm5;
        logic [2:0]               ngrp;
    } vinsn_t;

    function automatic logic op_supported(input logic [6:0] f7, input logic [2:0] f3);
        return (f7 == VOP_ADD || f7 == VOP_SUB || f7 == VOP_MUL || f7 == VOP_DIV) &&
               (f3 == VFMT_VV || f3 == VFMT_VX || f3 == VFMT_VI);
    endfunction

endpackage

// File: rtl/vexec_ctrl_opmux.sv
// vexec_opmux: selects VALU operand 2 (vector, broadcast scalar) and sign-extends the VI immediate
module vexec_opmux
    import vexec_pkg::*;
#(
    parameter int VLEN      = 256,
    parameter int ELEM_SIZE = 32
) (
    input  logic [2:0]           funct3,
    input  logic [VLEN-1:0]      rdata2,
    input  logic [ELEM_SIZE-1:0] scalar,
    input  logic [4:0]           imm5,
    output logic [VLEN-1:0]      op2,
    output logic [ELEM_SIZE-1:0] imm
);

    // VI leaves op2 at zero because the VALU takes its second operand from imm
    always_comb begin
        op2 = funct3 == VFMT_VV ? rdata2 :
              funct3 == VFMT_VX ? {(VLEN/ELEM_SIZE){scalar}} : '0;
        imm = {{(ELEM_SIZE-5){imm5[4]}}, imm5};
    end

endmodule

// File: rtl/vexec_ctrl.sv
// vexec_ctrl: strip-mining sequencer for the vector ALU (read, execute, writeback per group register); optional perf counters under VEXEC_CTRL_PERF_EN
module vexec_ctrl
    import vexec_pkg::*;
#(
    parameter int VLEN      = 256,
    parameter int ELEM_SIZE = PKG_ELEM_SIZE,
    parameter int NUM_VREGS = 32,
    parameter int VREG_AW   = PKG_VREG_AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6:0]           in_funct7,
    input  logic [2:0]           in_funct3,
    input  logic [VREG_AW-1:0]   in_vd,
    input  logic [VREG_AW-1:0]   in_vs1,
    input  logic [VREG_AW-1:0]   in_vs2,
    input  logic [ELEM_SIZE-1:0] in_scalar,
    input  logic [4:0]           in_imm5,
    input  logic [2:0]           in_ngrp,
    output logic                 vrf_re,
    output logic [VREG_AW-1:0]   vrf_raddr1,
    output logic [VREG_AW-1:0]   vrf_raddr2,
    input  logic [VLEN-1:0]      vrf_rdata1,
    input  logic [VLEN-1:0]      vrf_rdata2,
    output logic [VLEN-1:0]      valu_op1,
    output logic [VLEN-1:0]      valu_op2,
    output logic [ELEM_SIZE-1:0] valu_imm,
    output logic [6:0]           valu_funct7,
    output logic [2:0]           valu_funct3,
    input  logic [VLEN-1:0]      valu_result,
    output logic                 vrf_we,
    output logic [VREG_AW-1:0]   vrf_waddr,
    output logic [VLEN-1:0]      vrf_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err
`ifdef VEXEC_CTRL_PERF_EN
    ,
    output logic [31:0]          perf_insn,
    output logic [31:0]          perf_busy_cyc,
    output logic [15:0]          perf_err
`endif
);

    localparam logic [VREG_AW:0] LAST_REG = (VREG_AW+1)'(NUM_VREGS - 1);

    vexec_state_t        state, state_nxt;
    vinsn_t              insn;
    logic [2:0]          k;
    logic                accept, reject, last;
    logic [VREG_AW:0]    vd_end, vs1_end, vs2_end;
    logic [VLEN-1:0]     mux_op2;

    // End addresses carry one extra bit so a group running past the last register is caught, not wrapped
    assign vd_end  = {1'b0, in_vd}  + {{(VREG_AW-2){1'b0}}, in_ngrp};
    assign vs1_end = {1'b0, in_vs1} + {{(VREG_AW-2){1'b0}}, in_ngrp};
    assign vs2_end = {1'b0, in_vs2} + {{(VREG_AW-2){1'b0}}, in_ngrp};
    assign reject  = !op_supported(in_funct7, in_funct3) ||
                     vd_end > LAST_REG || vs1_end > LAST_REG || vs2_end > LAST_REG;
    assign accept  = in_valid && in_ready;
    assign last    = k == insn.ngrp;

    // State register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;

    // Next state: one RD/EX/WB pass per group register, rejects detour through ERR
    always_comb
        state_nxt = state == S_IDLE ? (accept ? (reject ? S_ERR : S_RD) : S_IDLE) :
                    state == S_RD   ? S_EX :
                    state == S_EX   ? S_WB :
                    (state == S_WB && !last) ? S_RD : S_IDLE;

    // Latch the instruction on accept and step the group index after each non-final writeback
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            insn <= '0;
            k    <= '0;
        end else if (accept) begin
            insn <= '{funct7: in_funct7, funct3: in_funct3, vd: in_vd, vs1: in_vs1, vs2: in_vs2,
                      scalar: in_scalar, imm5: in_imm5, ngrp: in_ngrp};
            k    <= '0;
        end else if (state == S_WB && !last) begin
            k <= k + 3'd1;
        end

    vexec_opmux #(.VLEN(VLEN), .ELEM_SIZE(ELEM_SIZE)) u_opmux (
        .funct3 (insn.funct3),
        .rdata2 (vrf_rdata2),
        .scalar (insn.scalar),
        .imm5   (insn.imm5),
        .op2    (mux_op2),
        .imm    (valu_imm)
    );

    // Outputs decoded from state; address/data buses are zero outside their strobe
    always_comb begin
        in_ready    = state == S_IDLE;
        busy        = state != S_IDLE;
        vrf_re      = state == S_RD;
        vrf_raddr1  = vrf_re ? insn.vs1 + VREG_AW'(k) : '0;
        vrf_raddr2  = vrf_re ? insn.vs2 + VREG_AW'(k) : '0;
        valu_op1    = state == S_EX ? vrf_rdata1 : '0;
        valu_op2    = state == S_EX ? mux_op2 : '0;
        valu_funct7 = insn.funct7;
        valu_funct3 = insn.funct3;
        vrf_we      = state == S_WB;
        vrf_waddr   = vrf_we ? insn.vd + VREG_AW'(k) : '0;
        vrf_wdata   = vrf_we ? valu_result : '0;
        done        = vrf_we && last;
        err         = state == S_ERR;
    end

`ifdef VEXEC_CTRL_PERF_EN
    // Free-running wrap-around event counters
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            perf_insn     <= '0;
            perf_busy_cyc <= '0;
            perf_err      <= '0;
        end else begin
            perf_insn     <= perf_insn + 32'(done);
            perf_busy_cyc <= perf_busy_cyc + 32'(busy);
            perf_err      <= perf_err + 16'(err);
        end
`endif

endmodule

// File: tb/tb_vexec_ctrl.sv
// tb_vexec_ctrl: directed and random checks of vexec_ctrl against a register-file-level reference model
module tb_vexec_ctrl;
    import vexec_pkg::*;

    localparam int VLEN = 256;
    localparam int ES   = 32;
    localparam int NE   = VLEN / ES;
    localparam int AW   = 5;

    logic            clk = 0;
    logic            rst_n = 1;
    logic            in_valid, in_ready;
    logic [6:0]      in_funct7;
    logic [2:0]      in_funct3;
    logic [AW-1:0]   in_vd, in_vs1, in_vs2;
    logic [ES-1:0]   in_scalar;
    logic [4:0]      in_imm5;
    logic [2:0]      in_ngrp;
    logic            vrf_re;
    logic [AW-1:0]   vrf_raddr1, vrf_raddr2;
    logic [VLEN-1:0] vrf_rdata1, vrf_rdata2;
    logic [VLEN-1:0] valu_op1, valu_op2;
    logic [ES-1:0]   valu_imm;
    logic [6:0]      valu_funct7;
    logic [2:0]      valu_funct3;
    logic [VLEN-1:0] valu_result;
    logic            vrf_we;
    logic [AW-1:0]   vrf_waddr;
    logic [VLEN-1:0] vrf_wdata;
    logic            busy, done, err;

    always #5 clk = ~clk;

    vexec_ctrl dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_funct7(in_funct7), .in_funct3(in_funct3), .in_vd(in_vd), .in_vs1(in_vs1),
        .in_vs2(in_vs2), .in_scalar(in_scalar), .in_imm5(in_imm5), .in_ngrp(in_ngrp),
        .vrf_re(vrf_re), .vrf_raddr1(vrf_raddr1), .vrf_raddr2(vrf_raddr2),
        .vrf_rdata1(vrf_rdata1), .vrf_rdata2(vrf_rdata2), .valu_op1(valu_op1),
        .valu_op2(valu_op2), .valu_imm(valu_imm), .valu_funct7(valu_funct7),
        .valu_funct3(valu_funct3), .valu_result(valu_result), .vrf_we(vrf_we),
        .vrf_waddr(vrf_waddr), .vrf_wdata(vrf_wdata), .busy(busy), .done(done), .err(err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] alu_e(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
        if (f7 == VOP_ADD) return a + b;
        if (f7 == VOP_SUB) return a - b;
        if (f7 == VOP_MUL) return a * b;
        if (f7 == VOP_DIV) return b == 0 ? 32'hFFFF_FFFF : a / b;
        return 32'd0;
    endfunction

    function automatic logic [VLEN-1:0] init_val(input int r);
        logic [VLEN-1:0] v;
        for (int e = 0; e < NE; e++)
            v[e*ES +: ES] = r == 2 ? 32'd5 : r == 3 ? 32'd7 : (r >= 8 && r <= 11) ? 32'd10 :
                            r == 20 ? 32'd3 : 32'(r * 1000 + e + 1);
        return v;
    endfunction

    function automatic logic [VLEN-1:0] splat(input logic [31:0] x);
        return {NE{x}};
    endfunction

    // Bench-side VRF (written only by the DUT) and a one-cycle-latency VALU
    logic [VLEN-1:0] mem [32];
    bit loaded = 0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int r = 0; r < 32; r++) mem[r] <= init_val(r);
            loaded <= 1;
        end else if (vrf_we) begin
            mem[vrf_waddr] <= vrf_wdata;
        end
        if (vrf_re) begin
            vrf_rdata1 <= mem[vrf_raddr1];
            vrf_rdata2 <= mem[vrf_raddr2];
        end
        for (int e = 0; e < NE; e++)
            valu_result[e*ES +: ES] <= alu_e(valu_funct7, valu_op1[e*ES +: ES],
                                             valu_funct3 == VFMT_VI ? valu_imm : valu_op2[e*ES +: ES]);
    end

    // Reference model: architectural register file plus a schedule of expected writes
    typedef struct { int c; int a; logic [VLEN-1:0] d; bit last; } wr_t;
    wr_t q[$];
    logic [VLEN-1:0] gold [32];
    int free_at = 0;
    int err_cyc = -1;
    bit gold_ok = 0;
    bit er, ew, el;

    task automatic model_accept(input int n);
        logic [VLEN-1:0] t [32];
        logic [31:0] b;
        int ng, vd, vs1, vs2;
        ng = int'(in_ngrp); vd = int'(in_vd); vs1 = int'(in_vs1); vs2 = int'(in_vs2);
        if (!(in_funct7 inside {VOP_ADD, VOP_SUB, VOP_MUL, VOP_DIV}) ||
            !(in_funct3 inside {VFMT_VV, VFMT_VX, VFMT_VI}) ||
            vd + ng > 31 || vs1 + ng > 31 || vs2 + ng > 31) begin
            err_cyc = n;
            free_at = n + 1;
        end else begin
            for (int r = 0; r < 32; r++) t[r] = gold[r];
            for (int j = 0; j <= ng; j++) begin
                for (int e = 0; e < NE; e++) begin
                    b = in_funct3 == VFMT_VV ? t[vs2+j][e*ES +: ES] :
                        in_funct3 == VFMT_VX ? in_scalar : {{27{in_imm5[4]}}, in_imm5};
                    t[vd+j][e*ES +: ES] = alu_e(in_funct7, t[vs1+j][e*ES +: ES], b);
                end
                q.push_back('{n + 3*j + 2, vd + j, t[vd+j], j == ng});
            end
            free_at = n + 3 * (ng + 1);
        end
    endtask

    // Per-cycle compare of handshake, strobes and writeback against the model
    always @(negedge clk) begin
        if (!gold_ok) begin
            for (int r = 0; r < 32; r++) gold[r] = init_val(r);
            gold_ok = 1;
        end
        if (!rst_n) begin
            q.delete();
            free_at = 0;
            err_cyc = -1;
            chk("rst_in_ready", in_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_vrf_we", vrf_we, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
        end else begin
            er = cyc >= free_at;
            ew = q.size() > 0 && q[0].c == cyc;
            el = ew && q[0].last;
            chk("in_ready", in_ready, er);
            chk("busy", busy, !er);
            chk("vrf_we", vrf_we, ew);
            chk("done", done, el);
            chk("err", err, cyc == err_cyc);
            if (ew && vrf_we) begin
                chk("vrf_waddr", vrf_waddr, q[0].a);
                chk("vrf_wdata", vrf_wdata, q[0].d);
            end
            if (ew) begin
                gold[q[0].a] = q[0].d;
                void'(q.pop_front());
            end
            if (in_valid && er) model_accept(cyc + 1);
        end
    end

    task automatic issue(input logic [6:0] f7, input logic [2:0] f3, input int vd, input int vs1,
                         input int vs2, input logic [31:0] sc, input logic [4:0] imm, input int ng,
                         output int lat);
        int w;
        @(posedge clk); #3;
        in_funct7 = f7; in_funct3 = f3; in_vd = AW'(vd); in_vs1 = AW'(vs1); in_vs2 = AW'(vs2);
        in_scalar = sc; in_imm5 = imm; in_ngrp = 3'(ng); in_valid = 1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        if (!in_ready) begin checks++; errors++; $display("FAIL accept_timeout: in_ready stuck at 0"); end
        @(posedge clk); #3;
        in_valid = 0;
        in_funct7 = 7'($urandom); in_funct3 = 3'($urandom); in_vd = AW'($urandom);
        in_vs1 = AW'($urandom); in_vs2 = AW'($urandom); in_scalar = $urandom;
        in_imm5 = 5'($urandom); in_ngrp = 3'($urandom);
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (done || err) break;
        end
        if (!(done || err)) begin checks++; errors++; $display("FAIL completion_timeout: no done/err within 40 cycles"); end
    endtask

    task automatic wait_flag(input bit want_done, input string name);
        int w;
        w = 0;
        while (!(want_done ? done : in_ready) && w < 60) begin @(negedge clk); w++; end
        if (!(want_done ? done : in_ready)) begin checks++; errors++; $display("FAIL %s: timeout", name); end
    endtask

    initial begin
        int lat;
        logic [VLEN-1:0] pre25;
        logic [6:0] ops [4];
        logic [2:0] fmts [3];
        int ng, r;
        ops[0] = VOP_ADD; ops[1] = VOP_SUB; ops[2] = VOP_MUL; ops[3] = VOP_DIV;
        fmts[0] = VFMT_VV; fmts[1] = VFMT_VX; fmts[2] = VFMT_VI;
        in_valid = 0; in_funct7 = 0; in_funct3 = 0; in_vd = 0; in_vs1 = 0; in_vs2 = 0;
        in_scalar = 0; in_imm5 = 0; in_ngrp = 0;
        #1 rst_n = 0;
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_vrf_we", vrf_we, 0);
        chk("reset_vrf_re", vrf_re, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1;

        issue(VOP_ADD, VFMT_VV, 4, 2, 3, 0, 0, 0, lat);
        chk("vv_add_latency", lat, 3);
        @(posedge clk); #1;
        chk("vv_add_v4", mem[4], splat(32'd12));

        issue(VOP_SUB, VFMT_VX, 12, 8, 0, 1, 0, 3, lat);
        chk("vx_sub_latency", lat, 12);
        @(posedge clk); #1;
        chk("vx_sub_v12", mem[12], splat(32'd9));
        chk("vx_sub_v15", mem[15], splat(32'd9));

        issue(VOP_ADD, VFMT_VI, 21, 20, 0, 0, 5'b11110, 0, lat);
        @(posedge clk); #1;
        chk("vi_neg_imm", mem[21], splat(32'd1));
        issue(VOP_ADD, VFMT_VI, 22, 20, 0, 0, 5'b01111, 0, lat);
        @(posedge clk); #1;
        chk("vi_pos_imm", mem[22], splat(32'd18));

        issue(7'b1111111, VFMT_VV, 1, 2, 3, 0, 0, 0, lat);
        chk("bad_funct7_err_cycle", lat, 1);
        @(negedge clk);
        chk("bad_funct7_ready", in_ready, 1);
        issue(VOP_ADD, VFMT_VV, 30, 2, 3, 0, 0, 2, lat);
        chk("vd_overflow_err_cycle", lat, 1);
        @(negedge clk);
        chk("vd_overflow_ready", in_ready, 1);

        @(posedge clk); #3;
        in_funct7 = VOP_ADD; in_funct3 = VFMT_VV; in_vd = 16; in_vs1 = 8; in_vs2 = 2;
        in_ngrp = 1; in_valid = 1;
        @(negedge clk);
        wait_flag(0, "busy_a_accept");
        @(posedge clk); #3;
        in_funct7 = VOP_MUL; in_funct3 = VFMT_VX; in_vd = 18; in_vs1 = 3; in_vs2 = 0;
        in_scalar = 2; in_ngrp = 0;
        @(negedge clk);
        chk("busy_ignores_valid", in_ready, 0);
        wait_flag(1, "busy_a_done");
        @(negedge clk);
        wait_flag(0, "busy_b_accept");
        @(posedge clk); #3;
        in_valid = 0;
        @(negedge clk);
        wait_flag(1, "busy_b_done");
        @(posedge clk); #1;
        chk("busy_a_v16", mem[16], splat(32'd15));
        chk("busy_a_v17", mem[17], splat(32'd17));
        chk("busy_b_v18", mem[18], splat(32'd14));

        pre25 = mem[25];
        @(posedge clk); #3;
        in_funct7 = VOP_ADD; in_funct3 = VFMT_VV; in_vd = 24; in_vs1 = 8; in_vs2 = 2;
        in_ngrp = 3; in_valid = 1;
        @(negedge clk);
        wait_flag(0, "rst_accept");
        @(posedge clk); #3;
        in_valid = 0;
        repeat (5) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midop_rst_we", vrf_we, 0);
        chk("midop_rst_busy", busy, 0);
        chk("midop_rst_ready", in_ready, 1);
        @(posedge clk); #3 rst_n = 1;
        repeat (2) @(posedge clk); #1;
        chk("midop_v24_written", mem[24], splat(32'd15));
        chk("midop_v25_untouched", mem[25], pre25);

        for (int i = 0; i < 150; i++) begin
            ng = $urandom_range(0, 7);
            r = $urandom_range(0, 9);
            issue(r < 9 ? ops[r % 4] : 7'($urandom),
                  $urandom_range(0, 9) < 9 ? fmts[$urandom_range(0, 2)] : 3'($urandom),
                  $urandom_range(0, 4) < 4 ? $urandom_range(0, 31 - ng) : $urandom_range(0, 31),
                  $urandom_range(0, 31 - ng), $urandom_range(0, 31 - ng),
                  $urandom_range(0, 7) == 0 ? 32'd0 : $urandom, 5'($urandom), ng, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vexec_ctrl.md
Name: vexec_ctrl

Overview:
- Sequencer for the vector ALU: accepts one vector arithmetic instruction at a time, reads operands from the vector register file (VRF), drives the VALU, and writes results back.
- Strip-mines register groups of 1-8 consecutive registers.
- Broadcasts scalar or immediate operands for VX/VI forms.
- Sits between the decode/issue stage and the VALU/VRF pair.

Parameters:
- VLEN, 256, vector register width in bits.
- ELEM_SIZE, 32, element width in bits.
- NUM_VREGS, 32, number of architectural vector registers.
- VREG_AW, 5, register address width (clog2 of NUM_VREGS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept an instruction.
- in_funct7  in  7  operation: 0000000 ADD, 0000100 SUB, 1001011 MUL, 1001100 DIV.
- in_funct3  in  3  000 VV, 100 VX, 011 VI.
- in_vd / in_vs1 / in_vs2  in  VREG_AW each  base register numbers.
- in_scalar  in  ELEM_SIZE  rs1 value for VX.
- in_imm5  in  5  VI immediate, sign-extended.
- in_ngrp  in  3  group size minus 1 (0 to 7).
- vrf_re  out  1  VRF read strobe.
- vrf_raddr1 / vrf_raddr2  out  VREG_AW each  read addresses.
- vrf_rdata1 / vrf_rdata2  in  VLEN each  read data, valid one cycle after vrf_re.
- valu_op1 / valu_op2  out  VLEN each  VALU operands.
- valu_imm  out  ELEM_SIZE  VALU immediate.
- valu_funct7  out  7  VALU operation select.
- valu_funct3  out  3  VALU operand-form select.
- valu_result  in  VLEN  VALU registered result, one-cycle latency.
- vrf_we  out  1  VRF write strobe.
- vrf_waddr  out  VREG_AW  write address.
- vrf_wdata  out  VLEN  write data.
- busy  out  1  instruction in flight.
- done  out  1  one-cycle pulse on the final writeback.
- err  out  1  one-cycle pulse on instruction rejection.

Behaviour:
- Reset values: all outputs 0 except in_ready=1; FSM=IDLE.
- Handshake: accept when in_valid && in_ready. Accepted fields are latched into internal registers.
- in_ready=1 only in IDLE. in_valid is ignored while busy; no queuing.
- FSM states: IDLE, RD, EX, WB, ERR.
  - IDLE: on accept, go to RD with k=0. If a reject condition holds, go to ERR instead.
  - RD: vrf_re=1, raddr1=vs1+k, raddr2=vs2+k; go to EX.
  - EX: valu_op1=vrf_rdata1. valu_op2 is vrf_rdata2 (VV), in_scalar replicated to every element (VX), or don't-care (VI). valu_imm = sign-extended imm5. funct7/funct3 are driven from the latched instruction. Go to WB.
  - WB: vrf_we=1, waddr=vd+k, wdata=valu_result. If k==ngrp, assert done and go to IDLE. Otherwise k++ and go to RD.
  - ERR: err=1 for one cycle, no VRF write; go to IDLE.
- Reject conditions:
  - funct7 not in the supported set.
  - funct3 not in {000, 100, 011}.
  - vd+ngrp, vs1+ngrp or vs2+ngrp > NUM_VREGS-1. No wrap-around.
- Latency: 3 cycles per group register. A 1-register op takes 3 cycles from the accept edge to done. 8 registers take 24 cycles.
- busy=1 in every state except IDLE.
- valu_funct7/valu_funct3 are held stable from EX through WB.
- Division by zero is passed through to the VALU; the controller does not check for it.
- Register address arithmetic is VREG_AW+1 bits wide so overflow detection is exact.
- Reset mid-operation: immediate return to IDLE. No further vrf_we; no done or err pulse.
- done and err are never asserted in the same cycle.

Optional Feature:
- Macro: VEXEC_CTRL_PERF_EN.
- When defined: adds outputs perf_insn (32-bit count of completed instructions), perf_busy_cyc (32-bit count of cycles with busy=1) and perf_err (16-bit count of rejects).
  - All counters wrap at 2^width and clear on reset.
- When not defined: these ports and counters do not exist.

Decomposition:
- Package vexec_pkg holds:
  - funct7 constants: VOP_ADD, VOP_SUB, VOP_MUL, VOP_DIV.
  - funct3 constants: VFMT_VV, VFMT_VX, VFMT_VI.
  - enum vexec_state_t.
  - typedef vinsn_t, a packed struct of the latched instruction fields.
- One sub-module: vexec_opmux, a combinational op2 broadcast/select plus immediate sign-extension.

Test Plan:
- VV ADD, ngrp=0, vs1=v2 all elements 5, vs2=v3 all elements 7, vd=v4 -> one write: v4 = all elements 12. done exactly 3 cycles after accept.
- VX SUB, ngrp=3, scalar=1, vs1=v8..v11 each element 10 -> four writes to v12..v15 in order, each element 9, one write every 3 cycles; done on the 4th write only.
- VI ADD, imm5=5'b11110 (-2), vs1 element 0x3 -> 0x1. Imm5 5'b01111 -> valu_imm=15.
- funct7=7'b1111111, or vd=30 with ngrp=2 -> err pulse, no vrf_we, in_ready back to 1 two cycles after accept.
- in_valid held high with new fields while busy -> ignored. The second instruction is accepted only once in_ready=1.
- rst_n asserted during WB of register k=1 of 4 -> no further writes, busy=0, in_ready=1 immediately. Next instruction then executes normally.
